// File: rtl/serial_echo_fifo_if.sv
// serial_echo_fifo_if: serial pins and status of the buffered echo engine
interface serial_echo_fifo_if #(
  parameter int NumberOfLEDs = 1,
  parameter int AW = 4
);
  logic                    RxD;
  logic                    TxD;
  logic [NumberOfLEDs-1:0] LED;
  logic [AW:0]             fifo_count;
  logic                    overflow;
  modport master (output RxD, input TxD, LED, fifo_count, overflow);
  modport slave (input RxD, output TxD, LED, fifo_count, overflow);
endinterface

// File: rtl/serial_echo_fifo.sv
// serial_echo_fifo: UART echo with a DEPTH-entry receive FIFO; define SERIAL_ECHO_CASE_EN
// to swap letter case instead of adding OFFSET to each echoed byte.
module async_receiver #(
  parameter int ClkFrequency = 24000000,
  parameter int Baud = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data
);
  localparam logic [15:0] DIV = 16'(ClkFrequency / Baud);
  localparam logic [15:0] HALF = DIV >> 1;
  logic [1:0]  rx_sync;
  logic        busy;
  logic [15:0] cnt;
  logic [3:0]  bitn;
  logic [7:0]  sr;
  // bit 0 is the start-bit check; 1..8 data; 9 the stop bit, sampled mid-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      busy <= 1'b0;
      cnt <= '0;
      bitn <= '0;
      sr <= '0;
      RxD_data <= '0;
      RxD_data_ready <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], RxD};
      RxD_data_ready <= 1'b0;
      if (!busy) begin
        if (!rx_sync[1]) begin
          busy <= 1'b1;
          cnt <= HALF;
          bitn <= 4'd0;
        end
      end else if (cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end else begin
        cnt <= DIV - 16'd1;
        if (bitn == 4'd0) begin
          if (rx_sync[1]) busy <= 1'b0;
          else bitn <= 4'd1;
        end else if (bitn < 4'd9) begin
          sr <= {rx_sync[1], sr[7:1]};
          bitn <= bitn + 4'd1;
        end else begin
          busy <= 1'b0;
          if (rx_sync[1]) begin
            RxD_data <= sr;
            RxD_data_ready <= 1'b1;
          end
        end
      end
    end
  end
endmodule

module async_transmitter #(
  parameter int ClkFrequency = 24000000,
  parameter int Baud = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);
  localparam logic [15:0] DIV = 16'(ClkFrequency / Baud);
  logic [15:0] cnt;
  logic [3:0]  bitn;
  logic [8:0]  sr;
  // sr carries the data bits with the stop bit above them, shifted out LSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TxD <= 1'b1;
      TxD_busy <= 1'b0;
      cnt <= '0;
      bitn <= '0;
      sr <= '1;
    end else if (!TxD_busy) begin
      if (TxD_start) begin
        TxD_busy <= 1'b1;
        TxD <= 1'b0;
        sr <= {1'b1, TxD_data};
        cnt <= DIV - 16'd1;
        bitn <= 4'd0;
      end
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end else if (bitn == 4'd9) begin
      TxD_busy <= 1'b0;
    end else begin
      TxD <= sr[0];
      sr <= {1'b1, sr[8:1]};
      bitn <= bitn + 4'd1;
      cnt <= DIV - 16'd1;
    end
  end
endmodule

module serial_echo_fifo #(
  parameter int         ClkFrequency = 24000000,
  parameter int         Baud = 115200,
  parameter int         NumberOfLEDs = 1,
  parameter int         DEPTH = 16,
  parameter logic [7:0] OFFSET = 8'd1
) (
  input logic               clk,
  input logic               rst,
  serial_echo_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} state_t;
  state_t                  state, state_n;
  logic                    RxD_data_ready, TxD_busy, TxD_start;
  logic [7:0]              RxD_data, TxD_data, hold;
  logic [7:0]              mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    overflow;
  logic [NumberOfLEDs-1:0] led;
  logic                    full, push, pop, wr_en;
  async_receiver #(.ClkFrequency(ClkFrequency), .Baud(Baud)) rx (
    .clk(clk), .rst(rst), .RxD(bus.RxD),
    .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data)
  );
  async_transmitter #(.ClkFrequency(ClkFrequency), .Baud(Baud)) tx (
    .clk(clk), .rst(rst), .TxD_start(TxD_start), .TxD_data(TxD_data),
    .TxD(bus.TxD), .TxD_busy(TxD_busy)
  );
  assign full = count == (AW+1)'(DEPTH);
  assign push = RxD_data_ready;
  assign pop = state == IDLE && count != '0 && !TxD_busy;
  // a simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign wr_en = push && (!full || pop);
`ifdef SERIAL_ECHO_CASE_EN
  assign TxD_data = ((hold >= 8'h41 && hold <= 8'h5A) || (hold >= 8'h61 && hold <= 8'h7A))
                    ? hold ^ 8'h20 : hold;
`else
  assign TxD_data = hold + OFFSET;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pop ? LOAD : IDLE;
      LOAD:    state_n = SEND;
      SEND:    state_n = TxD_busy ? DRAIN : SEND;
      DRAIN:   state_n = TxD_busy ? DRAIN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      TxD_start <= 1'b0;
      hold <= '0;
    end else begin
      state <= state_n;
      TxD_start <= state_n == LOAD;
      if (pop) hold <= mem[rd_ptr];
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= RxD_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      led <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (wr_en && !pop) ? count + 1'b1 : (!wr_en && pop) ? count - 1'b1 : count;
      if (push && !wr_en) overflow <= 1'b1;
      if (push) led <= RxD_data[NumberOfLEDs-1:0];
    end
  end
  assign bus.LED = led;
  assign bus.fifo_count = count;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_serial_echo_fifo.sv
// tb_serial_echo_fifo: scoreboard bench; stimulus queues expected echoes, a TxD monitor decodes and compares
module tb_serial_echo_fifo;
  localparam int DIV = 16;
`ifdef SERIAL_ECHO_CASE_EN
  localparam bit CASE_EN = 1'b1;
`else
  localparam bit CASE_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_echo_fifo_if #(.NumberOfLEDs(4), .AW(2)) bus();
  serial_echo_fifo #(
    .ClkFrequency(1843200), .Baud(115200), .NumberOfLEDs(4), .DEPTH(4), .OFFSET(8'd1)
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic [7:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int frames = 0;
  int max_cnt = 0;
  bit mbusy = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic send(input logic [7:0] b, input logic [7:0] e, input bit expect_echo);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    if (expect_echo) exp_q.push_back(e);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.RxD = frame[i];
      repeat (DIV) @(negedge clk);
    end
  endtask
  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL %s: timeout with %0d echoes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (300) @(negedge clk);
  endtask
  initial begin
    int mcnt;
    logic [7:0] msr;
    logic [7:0] e;
    mcnt = 0;
    msr = '0;
    forever begin
      @(negedge clk);
      if (rst) mbusy = 1'b0;
      else begin
        if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
        if (!mbusy) begin
          if (!bus.TxD) begin
            mbusy = 1'b1;
            mcnt = 0;
          end
        end else begin
          mcnt++;
          if (mcnt > DIV && mcnt < 9 * DIV && mcnt % DIV == DIV / 2) msr = {bus.TxD, msr[7:1]};
          if (mcnt == 9 * DIV + DIV / 2) begin
            mbusy = 1'b0;
            frames++;
            chk("stop_bit", 32'(bus.TxD), 32'd1);
            if (exp_q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_echo: got %0h expected none", msr);
            end else begin
              e = exp_q.pop_front();
              chk("echo", 32'(msr), 32'(e));
            end
          end
        end
      end
    end
  end
  initial begin
    int frames_before;
    int n;
    bus.RxD = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(bus.TxD), 32'd1);
    chk("reset_count", 32'(bus.fifo_count), 32'd0);
    chk("reset_overflow", 32'(bus.overflow), 32'd0);
    chk("reset_led", 32'(bus.LED), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    max_cnt = 0;
    send(8'h41, CASE_EN ? 8'h61 : 8'h42, 1'b1);
    wait_drain("t1_drain", 4000);
    chk("t1_led", 32'(bus.LED), 32'h1);
    chk("t1_peak_count", 32'(max_cnt), 32'd1);
    chk("t1_count_after", 32'(bus.fifo_count), 32'd0);
    chk("t1_overflow", 32'(bus.overflow), 32'd0);
    send(8'hFF, CASE_EN ? 8'hFF : 8'h00, 1'b1);
    wait_drain("t2_drain", 4000);
    chk("t2_led", 32'(bus.LED), 32'hF);
    max_cnt = 0;
    for (int i = 0; i < 5; i++)
      send(8'(8'h10 + i), CASE_EN ? 8'(8'h10 + i) : 8'(8'h11 + i), 1'b1);
    wait_drain("t3_drain", 6000);
    chk("t3_peak_le_depth", 32'(max_cnt <= 4), 32'd1);
    chk("t3_overflow", 32'(bus.overflow), 32'd0);
    repeat (40) @(negedge clk);
    force dut.TxD_busy = 1'b1;
    for (int i = 0; i < 5; i++)
      send(8'(8'h20 + i), CASE_EN ? 8'(8'h20 + i) : 8'(8'h21 + i), i < 4);
    repeat (10) @(negedge clk);
    chk("t4_count_full", 32'(bus.fifo_count), 32'd4);
    chk("t4_overflow", 32'(bus.overflow), 32'd1);
    chk("t4_led", 32'(bus.LED), 32'h4);
    release dut.TxD_busy;
    wait_drain("t4_drain", 8000);
    chk("t4_count_after", 32'(bus.fifo_count), 32'd0);
    force dut.TxD_busy = 1'b1;
    send(8'h30, 8'h00, 1'b0);
    send(8'h31, 8'h00, 1'b0);
    send(8'h32, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    release dut.TxD_busy;
    n = 0;
    while (!mbusy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_frame_started", 32'(mbusy), 32'd1);
    chk("t5_queued", 32'(bus.fifo_count), 32'd2);
    repeat (70) @(negedge clk);
    frames_before = frames;
    rst = 1'b1;
    #1;
    chk("t5_txd_on_reset", 32'(bus.TxD), 32'd1);
    chk("t5_count_on_reset", 32'(bus.fifo_count), 32'd0);
    chk("t5_overflow_on_reset", 32'(bus.overflow), 32'd0);
    chk("t5_led_on_reset", 32'(bus.LED), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    chk("t5_no_echo_after_reset", 32'(frames), 32'(frames_before));
    chk("t5_txd_idle", 32'(bus.TxD), 32'd1);
`ifdef SERIAL_ECHO_CASE_EN
    send(8'h61, 8'h41, 1'b1);
    send(8'h5A, 8'h7A, 1'b1);
    send(8'h35, 8'h35, 1'b1);
    wait_drain("t6_drain", 6000);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
